// File: rtl/tile_writeback_pkg.sv
// Shared tile geometry, tile-RAM word addressing and writeback FSM state type.
package raster_pkg;

  localparam int unsigned TILE_W       = 32;
  localparam int unsigned TILE_H       = 32;
  localparam int unsigned PIX_PER_WORD = 4;
  localparam int unsigned WORD_W       = 64;
  localparam int unsigned TILE_WORDS   = TILE_W * TILE_H / PIX_PER_WORD;

  typedef struct packed {
    logic [4:0] y;
    logic [2:0] xw;
  } tile_addr_t;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_ROW,
    WB_DONE
  } wb_state_t;

  // Linear word index 0..255 maps directly onto {Y, X[4:2]}.
  function automatic tile_addr_t word_to_tile_addr(input logic [7:0] idx);
    return tile_addr_t'(idx);
  endfunction

endpackage

// File: rtl/tile_writeback_if.sv
// Avalon-MM burst write bus between tile_writeback (master) and frame memory (slave).
interface tile_writeback_if;

  logic [31:0] avm_address;
  logic [3:0]  avm_burstcount;
  logic        avm_write;
  logic [63:0] avm_writedata;
  logic [7:0]  avm_byteenable;
  logic        avm_waitrequest;

  modport master (
    output avm_address,
    output avm_burstcount,
    output avm_write,
    output avm_writedata,
    output avm_byteenable,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_burstcount,
    input  avm_write,
    input  avm_writedata,
    input  avm_byteenable,
    output avm_waitrequest
  );

endinterface

// File: rtl/tile_writeback_fifo.sv
// Small synchronous prefetch FIFO between the tile RAM read port and the burst writer.
module tile_prefetch_fifo
  import raster_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty   = (count == '0);
    full    = (count == (AW+1)'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rdata   = mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/tile_writeback.sv
// Streams a finished 32x32 RGB565 tile from the tile RAM to the framebuffer,
// one Avalon-MM burst of 8 beats per tile row.
module tile_writeback
  import raster_pkg::*;
#(
  parameter int unsigned FB_STRIDE  = 1280,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] tile_base,
  output logic        busy,
  output logic        done,
  output logic [7:0]  ram_addr,
  output logic        ram_rden,
  input  logic [63:0] ram_q,
  tile_writeback_if.master avm
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  wb_state_t   state;
  tile_addr_t  rd_addr;
  logic [8:0]  rd_idx;
  logic        rden_d;
  logic [2:0]  beat;
  logic [4:0]  row;
  logic [31:0] row_addr;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic [63:0]   fifo_head;

  logic [CW:0] credit;
  logic        issue;
  logic        accept;
  logic        row_end;

  tile_prefetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rden_d),
    .wdata (ram_q),
    .pop   (accept),
    .rdata (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign ram_addr            = rd_addr;
  assign avm.avm_address     = row_addr;
  assign avm.avm_burstcount  = 4'(BURST_LEN);
  assign avm.avm_write       = (state == WB_ROW) && !fifo_empty;
  assign avm.avm_writedata   = fifo_head;
  assign avm.avm_byteenable  = '1;

  // Credit counts words queued plus both read-pipeline stages, so a push never meets a full FIFO.
  always_comb begin
    credit  = (CW+1)'(fifo_count) + (CW+1)'(rden_d) + (CW+1)'(ram_rden);
    issue   = (state == WB_ROW) && (rd_idx != 9'(TILE_WORDS))
              && (credit < (CW+1)'(FIFO_DEPTH));
    accept  = avm.avm_write && !avm.avm_waitrequest;
    row_end = accept && (beat == 3'(BURST_LEN - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= WB_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      ram_rden <= 1'b0;
      rd_addr  <= '0;
      rd_idx   <= '0;
      rden_d   <= 1'b0;
      beat     <= '0;
      row      <= '0;
      row_addr <= '0;
    end else begin
      rden_d   <= ram_rden;
      ram_rden <= 1'b0;
      done     <= 1'b0;
      case (state)
        WB_IDLE: begin
          if (start) begin
            // First read issues alongside start acceptance to hide one cycle of latency.
            state    <= WB_ROW;
            busy     <= 1'b1;
            row_addr <= tile_base & ~32'h7;
            beat     <= '0;
            row      <= '0;
            ram_rden <= 1'b1;
            rd_addr  <= word_to_tile_addr(8'd0);
            rd_idx   <= 9'd1;
          end
        end
        WB_ROW: begin
          if (issue) begin
            ram_rden <= 1'b1;
            rd_addr  <= word_to_tile_addr(rd_idx[7:0]);
            rd_idx   <= rd_idx + 9'd1;
          end
          if (accept) beat <= beat + 3'd1;
          if (row_end) begin
            row_addr <= row_addr + 32'(FB_STRIDE);
            row      <= row + 5'd1;
            if (row == 5'(TILE_H - 1)) begin
              state <= WB_DONE;
              done  <= 1'b1;
            end
          end
        end
        WB_DONE: begin
          state <= WB_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= WB_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
